// File: rtl/mode_scheduler.sv
// Mode scheduler: owns the shared LCD character path and the four button lines,
// handing ownership between display modes via drain/blank/grant with alarm pre-emption.
module mode_scheduler #(
    parameter int         FRAME_LEN  = 32,
    parameter int         DIP_STABLE = 16,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dip_sw,
    input  logic [3:0] sw_in,
    input  logic       alarm_req,
    input  logic       en_clk,
    input  logic [4:0] index_char,
    input  logic [7:0] data_mode0,
    input  logic [7:0] data_mode1,
    input  logic [7:0] data_mode2,
    input  logic [7:0] data_mode3,
    output logic [7:0] data_char,
    output logic [3:0] sw_out0,
    output logic [3:0] sw_out1,
    output logic [3:0] sw_out2,
    output logic [3:0] sw_out3,
    output logic [1:0] mode,
    output logic       busy,
    output logic       alarm_active,
    output logic       rst_alarm
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    localparam int            CW          = $clog2(DIP_STABLE + 1);
    localparam logic [CW-1:0] STABLE_MAX  = CW'(DIP_STABLE);
    localparam logic [5:0]    FRAME_TICKS = 6'(FRAME_LEN);
    localparam logic [5:0]    LAST_INDEX  = 6'(FRAME_LEN - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_mode;
    logic [1:0]    r_target;
    logic [5:0]    r_blank_cnt;
    logic [3:0]    r_dip_prev;
    logic [CW-1:0] r_dip_cnt;
    logic          r_alarm_d;
    logic          r_rst_alarm;
    logic          r_sw_block;

    logic       w_valid;
    logic [1:0] w_req;
    logic       w_alarm_rise;
    logic       w_frame_end;
    logic [5:0] w_blank_inc;
    logic [1:0] w_target_upd;

    assign w_valid      = (r_dip_cnt == STABLE_MAX) && (r_dip_prev != 4'b0000);
    assign w_alarm_rise = alarm_req && !r_alarm_d;
    assign w_frame_end  = en_clk && ({1'b0, index_char} == LAST_INDEX);
    assign w_blank_inc  = r_blank_cnt + 6'd1;
    assign w_target_upd = w_valid ? w_req : r_target;

    // Lowest set bit of the stable dip value wins.
    always_comb begin
        w_req = 2'd0;
        if (r_dip_prev[0])      w_req = 2'd0;
        else if (r_dip_prev[1]) w_req = 2'd1;
        else if (r_dip_prev[2]) w_req = 2'd2;
        else if (r_dip_prev[3]) w_req = 2'd3;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dip_prev <= 4'b0000;
            r_dip_cnt  <= '0;
        end else begin
            r_dip_prev <= dip_sw;
            if (dip_sw != r_dip_prev)    r_dip_cnt <= '0;
            else if (!(r_dip_cnt == STABLE_MAX)) r_dip_cnt <= r_dip_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_RUN;
            r_mode      <= 2'd0;
            r_target    <= 2'd0;
            r_blank_cnt <= 6'd0;
            r_alarm_d   <= 1'b0;
            r_rst_alarm <= 1'b0;
            r_sw_block  <= 1'b0;
        end else begin
            r_rst_alarm <= 1'b0;
            r_alarm_d   <= alarm_req;
            if (sw_in == 4'b0000) r_sw_block <= 1'b0;

            if (w_alarm_rise) begin
                r_state     <= S_ALARM;
                r_mode      <= 2'd0;
                r_target    <= 2'd0;
                r_blank_cnt <= 6'd0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_valid && (w_req != r_mode)) begin
                            r_target <= w_req;
                            r_state  <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (w_valid && (w_req == r_mode)) begin
                            r_state <= S_RUN;
                        end else begin
                            r_target <= w_target_upd;
                            if (w_frame_end) begin
                                r_state     <= S_BLANK;
                                r_blank_cnt <= 6'd0;
                            end
                        end
                    end
                    S_BLANK: begin
                        r_target <= w_target_upd;
                        if (en_clk) begin
                            if (w_blank_inc == FRAME_TICKS) begin
                                r_mode      <= w_target_upd;
                                r_state     <= S_RUN;
                                r_blank_cnt <= 6'd0;
                            end else begin
                                r_blank_cnt <= w_blank_inc;
                            end
                        end
                    end
                    S_ALARM: begin
                        // A press acknowledges; block routing until the buttons are released.
                        if (sw_in != 4'b0000) begin
                            r_rst_alarm <= 1'b1;
                            r_sw_block  <= 1'b1;
                            r_state     <= S_RUN;
                        end else if (!alarm_req) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_RUN;
                endcase
            end
        end
    end

    // NOTE: every output gets a default before the conditional paths, so no latch is inferred.
    always_comb begin
        sw_out0 = 4'b0000;
        sw_out1 = 4'b0000;
        sw_out2 = 4'b0000;
        sw_out3 = 4'b0000;
        if ((r_state == S_RUN) && !r_sw_block) begin
            case (r_mode)
                2'd0:    sw_out0 = sw_in;
                2'd1:    sw_out1 = sw_in;
                2'd2:    sw_out2 = sw_in;
                default: sw_out3 = sw_in;
            endcase
        end

        case (r_mode)
            2'd0:    data_char = data_mode0;
            2'd1:    data_char = data_mode1;
            2'd2:    data_char = data_mode2;
            default: data_char = data_mode3;
        endcase
        if (r_state == S_BLANK) data_char = BLANK_CHAR;
    end

    assign mode         = r_mode;
    assign busy         = (r_state == S_DRAIN) || (r_state == S_BLANK);
    assign alarm_active = (r_state == S_ALARM);
    assign rst_alarm    = r_rst_alarm;

endmodule
